// File: rtl/neopixel_ctrl_arbiter.sv
// Two-requester round-robin arbiter sharing one neopixel control port (pattern sequencer = 0, processor bridge = 1).
// Latency: accept in T, write strobe T+1 / read address T+1..T+L, completion pulse T+2 (write) or T+L+1 (read).
// Backpressure: req_ready pulses only from IDLE; one transaction in flight, other requester waits with valid held.
//
// Ports:
//   clock, reset_n                  single clock, asynchronous active-low reset
//   req_valid/req_write_readf       per-requester command valid and direction (1=write, 0=read)
//   req_address/req_write_data      per-requester fields, requester i at [i*W +: W]
//   req_ready                       one-cycle accept pulse to the granted requester
//   rsp_valid/rsp_data              one-cycle completion pulse; read data held until next read completes
//   write_readf/address/write_data  control port toward neopixel
//   read_data                       read data from neopixel, sampled C_READ_LATENCY cycles after address
module neopixel_ctrl_arbiter #(
    parameter int C_ADDR_WIDTH   = 32,
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_READ_LATENCY = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write_readf,
    input  logic [2*C_ADDR_WIDTH-1:0] req_address,
    input  logic [2*C_DATA_WIDTH-1:0] req_write_data,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [C_DATA_WIDTH-1:0]   rsp_data,
    output logic                      write_readf,
    output logic [C_ADDR_WIDTH-1:0]   address,
    output logic [C_DATA_WIDTH-1:0]   write_data,
    input  logic [C_DATA_WIDTH-1:0]   read_data
);

    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;
    // Counter only has to hold L-1.
    localparam int CW = (C_READ_LATENCY > 1) ? $clog2(C_READ_LATENCY) : 1;

    generate
        if (C_READ_LATENCY < 1) begin : g_bad_latency
            $error("neopixel_ctrl_arbiter: C_READ_LATENCY must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;
    logic            r_grant;
    logic [AW-1:0]   r_address;
    logic [DW-1:0]   r_write_data;
    logic [DW-1:0]   r_rsp_data;
    logic [CW-1:0]   r_cnt;

    logic            w_grant_vld;
    logic            w_grant_idx;
    logic            w_take;
    logic            w_grant_wr;
    logic [AW-1:0]   w_grant_addr;
    logic [DW-1:0]   w_grant_wdata;
    logic            w_read_done;

    // Arbitration: a lone requester wins outright; a tie goes to whoever
    // was not served last. last_grant resets to 1 so the first tie picks 0.
    always_comb begin
        w_grant_vld   = |req_valid;
        w_grant_idx   = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
        w_take        = (r_state == S_IDLE) && w_grant_vld;
        w_grant_wr    = w_grant_idx ? req_write_readf[1] : req_write_readf[0];
        w_grant_addr  = w_grant_idx ? req_address[AW +: AW]    : req_address[0 +: AW];
        w_grant_wdata = w_grant_idx ? req_write_data[DW +: DW] : req_write_data[0 +: DW];
        w_read_done   = (r_state == S_READ) && (r_cnt == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld) begin
                    w_state_nxt = w_grant_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: w_state_nxt = S_RESP;
            S_READ: begin
                if (w_read_done) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
            r_rsp_data   <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_grant      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
                r_address    <= w_grant_addr;
                r_write_data <= w_grant_wdata;
                r_cnt        <= CW'(C_READ_LATENCY - 1);
            end else if ((r_state == S_READ) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Only a finished read touches rsp_data; write acks leave it alone.
            if (w_read_done) begin
                r_rsp_data <= read_data;
            end
        end
    end

    // req_ready is combinational from IDLE; gating with reset_n keeps every
    // output at zero while reset is held, even if requesters stay valid.
    always_comb begin
        req_ready = 2'b00;
        if (w_take && reset_n) begin
            req_ready = w_grant_idx ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (r_state == S_RESP) begin
            rsp_valid = r_grant ? 2'b10 : 2'b01;
        end
    end

    assign write_readf = (r_state == S_WRITE);
    assign address     = r_address;
    assign write_data  = r_write_data;
    assign rsp_data    = r_rsp_data;

    // Structural invariants of the grant logic.
    a_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(req_ready));
    a_ready_idle_only: assert property (@(posedge clock) disable iff (!reset_n)
        (req_ready != 2'b00) |-> (r_state == S_IDLE));
    a_rsp_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(rsp_valid));

endmodule

// File: tb/tb_neopixel_ctrl_arbiter.sv
module tb_neopixel_ctrl_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] GARB = 32'h1111_1111;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n;

    // DUT with read latency 2
    logic [1:0]    req_valid;
    logic [1:0]    req_write_readf;
    logic [2*AW-1:0] req_address;
    logic [2*DW-1:0] req_write_data;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          write_readf;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;

    // DUT with read latency 1
    logic [1:0]    req_valid_b;
    logic [1:0]    req_write_readf_b;
    logic [2*AW-1:0] req_address_b;
    logic [2*DW-1:0] req_write_data_b;
    logic [1:0]    req_ready_b;
    logic [1:0]    rsp_valid_b;
    logic [DW-1:0] rsp_data_b;
    logic          write_readf_b;
    logic [AW-1:0] address_b;
    logic [DW-1:0] write_data_b;
    logic [DW-1:0] read_data_b;

    int n_cmp = 0;
    int n_err = 0;

    neopixel_ctrl_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_READ_LATENCY(2)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_write_readf(req_write_readf),
        .req_address(req_address), .req_write_data(req_write_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .write_readf(write_readf), .address(address), .write_data(write_data),
        .read_data(read_data)
    );

    neopixel_ctrl_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_READ_LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid_b), .req_write_readf(req_write_readf_b),
        .req_address(req_address_b), .req_write_data(req_write_data_b),
        .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
        .write_readf(write_readf_b), .address(address_b), .write_data(write_data_b),
        .read_data(read_data_b)
    );

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
        n_cmp++; if (write_readf !== 1'b0) begin n_err++; $display("FAIL rst_write_readf: got %b want 0", write_readf); end
        n_cmp++; if (address !== 32'h0) begin n_err++; $display("FAIL rst_address: got %h want 0", address); end
        n_cmp++; if (write_data !== 32'h0) begin n_err++; $display("FAIL rst_write_data: got %h want 0", write_data); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        n_cmp++; if (rsp_data_b !== 32'h0) begin n_err++; $display("FAIL rst_rsp_data_l1: got %h want 0", rsp_data_b); end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL idle_ready: got %b want 00", req_ready); end
    endtask

    task automatic test_write();
        next_cycle();
        req_valid = 2'b01;
        req_write_readf[0] = 1'b1;
        req_address[0 +: AW] = 32'h4;
        req_write_data[0 +: DW] = 32'h00FF_0000;
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL wr_ready_T: got %b want 01", req_ready); end
        n_cmp++; if (write_readf !== 1'b0) begin n_err++; $display("FAIL wr_strobe_T: got %b want 0", write_readf); end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clock);
        n_cmp++; if (write_readf !== 1'b1) begin n_err++; $display("FAIL wr_strobe_T1: got %b want 1", write_readf); end
        n_cmp++; if (address !== 32'h4) begin n_err++; $display("FAIL wr_addr_T1: got %h want 4", address); end
        n_cmp++; if (write_data !== 32'h00FF_0000) begin n_err++; $display("FAIL wr_data_T1: got %h want 00ff0000", write_data); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_rsp_T1: got %b want 00", rsp_valid); end
        next_cycle();
        @(negedge clock);
        n_cmp++; if (write_readf !== 1'b0) begin n_err++; $display("FAIL wr_strobe_T2: got %b want 0", write_readf); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL wr_rsp_T2: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL wr_rsp_data: got %h want 0", rsp_data); end
        next_cycle();
        @(negedge clock);
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL wr_rsp_T3: got %b want 00", rsp_valid); end
    endtask

    task automatic test_read();
        next_cycle();
        req_valid = 2'b10;
        req_write_readf[1] = 1'b0;
        req_address[AW +: AW] = 32'h8;
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL rd_ready_T: got %b want 10", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        read_data = 32'hBAD0_0001;
        @(negedge clock);
        n_cmp++; if (address !== 32'h8) begin n_err++; $display("FAIL rd_addr_T1: got %h want 8", address); end
        n_cmp++; if (write_readf !== 1'b0) begin n_err++; $display("FAIL rd_strobe_T1: got %b want 0", write_readf); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_rsp_T1: got %b want 00", rsp_valid); end
        next_cycle();
        read_data = 32'hDEAD_BEEF;
        @(negedge clock);
        n_cmp++; if (address !== 32'h8) begin n_err++; $display("FAIL rd_addr_T2: got %h want 8", address); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_rsp_T2: got %b want 00", rsp_valid); end
        next_cycle();
        read_data = GARB;
        @(negedge clock);
        n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL rd_rsp_T3: got %b want 10", rsp_valid); end
        n_cmp++; if (rsp_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data_T3: got %h want deadbeef", rsp_data); end
    endtask

    // Both requesters valid every cycle straight out of reset.
    task automatic test_round_robin();
        logic [1:0] e_rdy;
        logic       e_wr;
        logic [1:0] e_rsp;
        logic [31:0] e_addr;
        int g;
        next_cycle();
        reset_n = 1'b0;
        req_valid = 2'b11;
        req_write_readf = 2'b11;
        req_address = {32'h200, 32'h100};
        req_write_data = {32'h2222_0000, 32'h1111_0000};
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) next_cycle();
            @(negedge clock);
            g      = (c / 3) % 2;
            e_rdy  = (c % 3 == 0) ? ((g != 0) ? 2'b10 : 2'b01) : 2'b00;
            e_wr   = (c % 3 == 1);
            e_rsp  = (c % 3 == 2) ? ((g != 0) ? 2'b10 : 2'b01) : 2'b00;
            e_addr = (g != 0) ? 32'h200 : 32'h100;
            n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, e_rdy); end
            n_cmp++; if (write_readf !== e_wr) begin n_err++; $display("FAIL rr_strobe c%0d: got %b want %b", c, write_readf, e_wr); end
            n_cmp++; if (rsp_valid !== e_rsp) begin n_err++; $display("FAIL rr_rsp c%0d: got %b want %b", c, rsp_valid, e_rsp); end
            if (e_wr) begin
                n_cmp++; if (address !== e_addr) begin n_err++; $display("FAIL rr_addr c%0d: got %h want %h", c, address, e_addr); end
            end
        end
        next_cycle();
        req_valid = 2'b00;
    endtask

    // req0 streams writes; req1 raises a read mid-stream and must be slotted in.
    task automatic test_mid_stream();
        logic [1:0] e_rdy [11] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        logic       e_wr  [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] e_rsp [11] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        int strobes = 0;
        for (int c = 0; c < 11; c++) begin
            next_cycle();
            case (c)
                0: begin
                    req_valid = 2'b01;
                    req_write_readf[0] = 1'b1;
                    req_address[0 +: AW] = 32'h10;
                    req_write_data[0 +: DW] = 32'hA;
                end
                1: begin
                    req_valid[1] = 1'b1;
                    req_write_readf[1] = 1'b0;
                    req_address[AW +: AW] = 32'h20;
                    req_address[0 +: AW] = 32'h14;
                    req_write_data[0 +: DW] = 32'hB;
                end
                4: req_valid[1] = 1'b0;
                5: read_data = 32'hCAFE_F00D;
                6: read_data = GARB;
                10: req_valid = 2'b00;
                default: ;
            endcase
            @(negedge clock);
            if (write_readf === 1'b1) strobes++;
            n_cmp++; if (req_ready !== e_rdy[c]) begin n_err++; $display("FAIL ms_ready c%0d: got %b want %b", c, req_ready, e_rdy[c]); end
            n_cmp++; if (write_readf !== e_wr[c]) begin n_err++; $display("FAIL ms_strobe c%0d: got %b want %b", c, write_readf, e_wr[c]); end
            n_cmp++; if (rsp_valid !== e_rsp[c]) begin n_err++; $display("FAIL ms_rsp c%0d: got %b want %b", c, rsp_valid, e_rsp[c]); end
            case (c)
                1: begin n_cmp++; if (address !== 32'h10) begin n_err++; $display("FAIL ms_addr c1: got %h want 10", address); end end
                5: begin n_cmp++; if (address !== 32'h20) begin n_err++; $display("FAIL ms_addr c5: got %h want 20", address); end end
                6: begin n_cmp++; if (rsp_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ms_rdata c6: got %h want cafef00d", rsp_data); end end
                8: begin
                    n_cmp++; if (address !== 32'h14) begin n_err++; $display("FAIL ms_addr c8: got %h want 14", address); end
                    n_cmp++; if (write_data !== 32'hB) begin n_err++; $display("FAIL ms_wdata c8: got %h want b", write_data); end
                end
                9: begin n_cmp++; if (rsp_data !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ms_rdata_kept c9: got %h want cafef00d", rsp_data); end end
                default: ;
            endcase
        end
        n_cmp++; if (strobes != 2) begin n_err++; $display("FAIL ms_strobe_count: got %0d want 2", strobes); end
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        req_valid = 2'b01;
        req_write_readf[0] = 1'b0;
        req_address[0 +: AW] = 32'h30;
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmr_ready_T: got %b want 01", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        @(negedge clock);
        n_cmp++; if (address !== 32'h30) begin n_err++; $display("FAIL rmr_addr_T1: got %h want 30", address); end
        next_cycle();
        reset_n = 1'b0;
        req_valid = 2'b11;
        #1;
        n_cmp++; if (address !== 32'h0) begin n_err++; $display("FAIL rmr_addr_rst: got %h want 0", address); end
        n_cmp++; if (write_data !== 32'h0) begin n_err++; $display("FAIL rmr_wdata_rst: got %h want 0", write_data); end
        n_cmp++; if (write_readf !== 1'b0) begin n_err++; $display("FAIL rmr_strobe_rst: got %b want 0", write_readf); end
        n_cmp++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rmr_rdata_rst: got %h want 0", rsp_data); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmr_ready_rst: got %b want 00", req_ready); end
        next_cycle();
        @(negedge clock);
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rmr_rsp_rst: got %b want 00", rsp_valid); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rmr_ready_rst2: got %b want 00", req_ready); end
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rmr_first_tie: got %b want 01", req_ready); end
        next_cycle();
        req_valid = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clock);
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rmr_rsp_after: got %b want 01", rsp_valid); end
    endtask

    task automatic test_latency1();
        next_cycle();
        req_valid_b = 2'b01;
        req_write_readf_b[0] = 1'b0;
        req_address_b[0 +: AW] = 32'h40;
        @(negedge clock);
        n_cmp++; if (req_ready_b !== 2'b01) begin n_err++; $display("FAIL l1_ready_T: got %b want 01", req_ready_b); end
        next_cycle();
        req_valid_b = 2'b00;
        read_data_b = 32'h5A5A_1234;
        @(negedge clock);
        n_cmp++; if (address_b !== 32'h40) begin n_err++; $display("FAIL l1_addr_T1: got %h want 40", address_b); end
        n_cmp++; if (rsp_valid_b !== 2'b00) begin n_err++; $display("FAIL l1_rsp_T1: got %b want 00", rsp_valid_b); end
        next_cycle();
        read_data_b = GARB;
        @(negedge clock);
        n_cmp++; if (rsp_valid_b !== 2'b01) begin n_err++; $display("FAIL l1_rsp_T2: got %b want 01", rsp_valid_b); end
        n_cmp++; if (rsp_data_b !== 32'h5A5A_1234) begin n_err++; $display("FAIL l1_rdata_T2: got %h want 5a5a1234", rsp_data_b); end
        next_cycle();
        @(negedge clock);
        n_cmp++; if (rsp_valid_b !== 2'b00) begin n_err++; $display("FAIL l1_rsp_T3: got %b want 00", rsp_valid_b); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n           = 1'b0;
        req_valid         = '0;
        req_write_readf   = '0;
        req_address       = '0;
        req_write_data    = '0;
        read_data         = GARB;
        req_valid_b       = '0;
        req_write_readf_b = '0;
        req_address_b     = '0;
        req_write_data_b  = '0;
        read_data_b       = GARB;

        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_mid_stream();
        test_reset_mid_read();
        test_latency1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
